// File: rtl/useq_mbox.sv
// Multi-channel message mailbox: CHANNELS independent WIDTH x DEPTH FIFOs.
// Supports a simultaneous push and pop per cycle, sticky overflow/underflow flags and a maskable irq.
module useq_mbox #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 16,
  parameter  int CHANNELS = 2,
  localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNTW     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [CHW-1:0]           wr_ch,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [CHW-1:0]           rd_ch,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [CHANNELS-1:0]      empty,
  output logic [CHANNELS-1:0]      full,
  output logic [CHANNELS*CNTW-1:0] count,
  input  logic [CHANNELS-1:0]      irq_mask,
  output logic                     irq,
  input  logic                     err_clr,
  output logic [CHANNELS-1:0]      ovf,
  output logic [CHANNELS-1:0]      udf
);

  localparam int PTRW = $clog2(DEPTH);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [WIDTH-1:0]    r_mem [CHANNELS][DEPTH];
  logic [PTRW-1:0]     r_wp  [CHANNELS];
  logic [PTRW-1:0]     r_rp  [CHANNELS];
  logic [CNTW-1:0]     r_cnt [CHANNELS];
  logic [WIDTH-1:0]    r_rd_data;
  logic                r_rd_valid;
  logic                r_irq;
  logic [CHANNELS-1:0] r_ovf;
  logic [CHANNELS-1:0] r_udf;

  logic [CHANNELS-1:0] w_wr_hit, w_wr_push, w_rd_hit, w_rd_pop;
  logic [CHANNELS-1:0] w_ovf_set, w_udf_set, w_nonempty_nxt;
  logic [CNTW-1:0]     w_cnt_nxt [CHANNELS];
  logic [WIDTH-1:0]    w_rd_data;
  logic                w_irq_nxt;

  always_comb begin
    w_wr_hit       = '0;
    w_wr_push      = '0;
    w_rd_hit       = '0;
    w_rd_pop       = '0;
    w_ovf_set      = '0;
    w_udf_set      = '0;
    w_nonempty_nxt = '0;
    w_rd_data      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_rd_hit[c]  = rd_en && (rd_ch == CHW'(c));
      w_rd_pop[c]  = w_rd_hit[c] && (r_cnt[c] != '0);
      w_wr_hit[c]  = wr_en && (wr_ch == CHW'(c));
      // A full channel still accepts a write when the same cycle pops it.
      w_wr_push[c] = w_wr_hit[c] && ((r_cnt[c] != FULL_CNT) || w_rd_pop[c]);
      w_cnt_nxt[c] = r_cnt[c] + CNTW'(w_wr_push[c]) - CNTW'(w_rd_pop[c]);
      w_ovf_set[c] = w_wr_hit[c] & ~w_wr_push[c];
      w_udf_set[c] = w_rd_hit[c] & ~w_rd_pop[c];
      w_nonempty_nxt[c] = (w_cnt_nxt[c] != '0);
      if (w_rd_pop[c]) w_rd_data = r_mem[c][r_rp[c]];
    end
    // Out-of-range channel selects are reported against channel 0.
    w_ovf_set[0] = w_ovf_set[0] | (wr_en & ~|w_wr_hit);
    w_udf_set[0] = w_udf_set[0] | (rd_en & ~|w_rd_hit);
    w_irq_nxt    = |(w_nonempty_nxt & irq_mask);
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_wr_push[c]) r_mem[c][r_wp[c]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_wp[c]  <= '0;
        r_rp[c]  <= '0;
        r_cnt[c] <= '0;
      end
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_irq      <= 1'b0;
      r_ovf      <= '0;
      r_udf      <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_wr_push[c]) r_wp[c] <= r_wp[c] + PTRW'(1);
        if (w_rd_pop[c])  r_rp[c] <= r_rp[c] + PTRW'(1);
        r_cnt[c] <= w_cnt_nxt[c];
      end
      r_rd_valid <= |w_rd_pop;
      if (|w_rd_pop) r_rd_data <= w_rd_data;
      r_irq <= w_irq_nxt;
      r_ovf <= (err_clr ? '0 : r_ovf) | w_ovf_set;
      r_udf <= (err_clr ? '0 : r_udf) | w_udf_set;
    end
  end

  always_comb begin
    empty = '0;
    full  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      empty[c] = (r_cnt[c] == '0);
      full[c]  = (r_cnt[c] == FULL_CNT);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_count
    assign count[g*CNTW +: CNTW] = r_cnt[g];
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign irq      = r_irq;
  assign ovf      = r_ovf;
  assign udf      = r_udf;

endmodule

// File: tb/tb_useq_mbox.sv
// Scoreboard bench for useq_mbox: a per-channel queue model predicts every output each cycle.
module tb_useq_mbox;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en, err_clr;
  logic [0:0] wr_ch, rd_ch;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid, irq;
  logic [1:0] empty, full, irq_mask, ovf, udf;
  logic [9:0] count;

  useq_mbox #(.WIDTH(8), .DEPTH(16), .CHANNELS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .full(full), .count(count),
    .irq_mask(irq_mask), .irq(irq),
    .err_clr(err_clr), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [7:0] sb[$];
  logic [1:0] m_ovf, m_udf;
  logic [7:0] m_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int msize(input int ch);
    return (ch == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic check_state(input logic exp_valid);
    logic [1:0] m_empty, m_full;
    logic [4:0] c0, c1;
    c0 = 5'(mq0.size());
    c1 = 5'(mq1.size());
    m_empty = {c1 == 0, c0 == 0};
    m_full  = {c1 == 16, c0 == 16};
    chk("rd_valid", rd_valid, exp_valid);
    if (rd_valid && sb.size() > 0) chk("rd_data", rd_data, sb.pop_front());
    else chk("rd_data_hold", rd_data, m_last);
    if (!rd_valid) sb.delete();
    chk("count", count, {c1, c0});
    chk("empty", empty, m_empty);
    chk("full", full, m_full);
    chk("ovf", ovf, m_ovf);
    chk("udf", udf, m_udf);
    chk("irq", irq, |(~m_empty & irq_mask));
  endtask

  task automatic step(input logic we, input int wc, input logic [7:0] wd,
                      input logic re, input int rc, input logic clr);
    logic       rok, wok;
    logic [7:0] v;
    wr_en = we; wr_ch = 1'(wc); wr_data = wd;
    rd_en = re; rd_ch = 1'(rc); err_clr = clr;
    rok = re && (msize(rc) != 0);
    if (rok) begin
      v = (rc == 0) ? mq0.pop_front() : mq1.pop_front();
      sb.push_back(v);
      m_last = v;
    end
    wok = we && (msize(wc) < 16);
    if (clr) begin m_ovf = '0; m_udf = '0; end
    if (wok) begin
      if (wc == 0) mq0.push_back(wd); else mq1.push_back(wd);
    end else if (we) m_ovf[wc] = 1'b1;
    if (re && !rok) m_udf[rc] = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    check_state(rok);
  endtask

  task automatic do_reset(input logic re, input int rc);
    rst_n = 1'b0; rd_en = re; rd_ch = 1'(rc);
    wr_en = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    rd_en = 1'b0;
    mq0.delete(); mq1.delete(); sb.delete();
    m_ovf = '0; m_udf = '0; m_last = '0;
    check_state(1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    irq_mask = 2'b11; wr_data = '0; wr_ch = '0; rd_ch = '0;
    do_reset(1'b0, 0);
    do_reset(1'b0, 0);

    foreach (mq0[i]) ;
    step(1, 1, 8'h11, 0, 0, 0);
    step(1, 1, 8'h22, 0, 0, 0);
    step(1, 1, 8'h33, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0);

    for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0, 0, 0);
    step(1, 0, 8'hAA, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0, 0, 0);
    step(1, 0, 8'h55, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0, 0);
    chk("last_drained", m_last, 8'h55);

    step(1, 1, 8'h77, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);

    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 8'hC0, 0, 0, 0);
    for (int i = 1; i < 40; i++) step(1, 0, 8'hC0 + 8'(i), 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 20; i++) begin
      int ch = $urandom_range(0, 1);
      step(1'($urandom_range(0, 1)), ch, 8'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 1), 1'($urandom_range(0, 7) == 0));
    end
    while (mq0.size() > 0) step(0, 0, 0, 1, 0, 0);
    while (mq1.size() > 0) step(0, 0, 0, 1, 1, 0);

    irq_mask = 2'b10;
    step(1, 0, 8'h01, 0, 0, 0);
    step(1, 1, 8'h02, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    irq_mask = 2'b11;

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1);

    step(1, 1, 8'h99, 0, 0, 0);
    do_reset(1'b1, 0);
    step(0, 0, 0, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/useq_mbox.md
# useq_mbox

Parametrised multi-channel message mailbox for the useq micro-sequencer family, replacing the single fixed 8-bit, 16-deep message FIFO embedded in each core. It provides CHANNELS independent WIDTH-bit FIFOs of DEPTH entries between a producer port and a consumer port, typically host ↔ core or core ↔ core. Unlike the embedded FIFO, it:
- accepts a write and a read in the same cycle, even to the same channel;
- reports overflow and underflow;
- drives a maskable non-empty interrupt.

## Interface
- WIDTH, 8, data bits per entry
- DEPTH, 16, entries per channel; power of two, ≥2
- CHANNELS, 2, number of independent FIFOs, ≥1
- CHW = max(1,$clog2(CHANNELS)), derived, channel-select width
- CNTW = $clog2(DEPTH+1), derived, count width
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- wr_en  in  1  write strobe, one entry per cycle
- wr_ch  in  CHW  target channel for write
- wr_data  in  WIDTH  write data
- rd_en  in  1  read strobe, one entry per cycle
- rd_ch  in  CHW  source channel for read
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  one-cycle pulse; rd_data holds a popped entry
- empty  out  CHANNELS  per-channel count==0, combinational from registered counts
- full  out  CHANNELS  per-channel count==DEPTH
- count  out  CHANNELS*CNTW  packed per-channel counts, channel 0 in LSBs
- irq_mask  in  CHANNELS  per-channel interrupt enable
- irq  out  1  registered |(~empty_next & irq_mask)
- err_clr  in  1  clears sticky error flags
- ovf  out  CHANNELS  sticky: write to full channel dropped
- udf  out  CHANNELS  sticky: read from empty channel, or out-of-range channel

## Operation
Storage:
- Per channel: DEPTH×WIDTH array, write pointer wp, read pointer rp (each $clog2(DEPTH) bits, natural wrap), count register (CNTW bits).
- Memory contents are not reset.

Reset values: all pointers and counts 0; rd_data 0; rd_valid 0; irq 0; ovf 0; udf 0. Therefore empty is all-ones and full is all-zeros.

Write (wr_en=1):
- If channel wr_ch is not full, or a same-channel read pops this cycle: store wr_data at wp, wp+1.
- Otherwise: drop the data, set ovf[wr_ch].
- wr_ch ≥ CHANNELS: drop, set ovf bit 0.

Read (rd_en=1):
- If channel rd_ch count≠0 at cycle start: rd_data←mem[rp], rp+1, rd_valid←1.
- Otherwise: rd_data holds its previous value, rd_valid←0, set udf[rd_ch].
- rd_ch ≥ CHANNELS: set udf bit 0.

Count update, per channel:
- +1 on accepted write only.
- −1 on accepted read only.
- Unchanged when both are accepted or neither is.

Same channel, same cycle:
- Full + write + read: both accepted; count stays DEPTH; the read returns the oldest entry.
- Empty + write + read: the read underflows (no write-through bypass); the write is accepted; count becomes 1.

Different channels in the same cycle operate fully independently.

Errors:
- A set and err_clr in the same cycle: set wins.
- err_clr alone zeroes all ovf and udf bits.

irq is computed from next-state counts, so it reflects the post-update state in the same cycle the counts update.

## Timing
- Write → visible: count, empty, full and irq update at the clock edge accepting the write; the entry is readable the following cycle.
- Read latency: 1 cycle. rd_data and rd_valid are valid the cycle after rd_en is sampled.
- Back-to-back reads: one per cycle, rd_valid held high continuously.
- Throughput: one write plus one read per cycle, aggregate across channels.
- Pointer wrap: after DEPTH accepted writes, wp returns to 0 with no bubble.
- Reset mid-operation: all state returns to reset values at the next edge; a rd_valid due that cycle is suppressed.

## Test plan
- Reset, then write 0x11,0x22,0x33 to ch1; read ch1 ×3 → rd_data 0x11,0x22,0x33 on consecutive cycles, rd_valid high 3 cycles; count[1] returns to 0; empty[1]=1.
- Fill ch0 with 16 entries (0x00–0x0F); write 0xAA → dropped, ovf[0]=1, full[0]=1; then read 16 → 0x00–0x0F in order; pulse err_clr → ovf=0.
- ch0 full, simultaneous write 0x55 and read ch0 → rd_data=0x00, count stays 16; after draining, the last entry read is 0x55.
- ch1 empty, simultaneous write 0x77 and read ch1 → rd_valid=0, udf[1]=1, count[1]=1; next read → 0x77.
- Pointer wrap: 40 interleaved write/read pairs on ch0 → every byte is returned in order, count never exceeds 1.
- irq_mask=2'b10; write ch0 → irq stays 0; write ch1 → irq=1 at the same edge; read ch1 → irq=0 at the read edge.
